// File: rtl/flip_sweep_sequencer_if.sv
// flip_sweep_sequencer_if
//   Bundles the configuration handshake, the abort request and the DUT-facing
//   outputs of the flip sweep sequencer.
//   master : configuration source (serial receiver / host side)
//     drives cfg_valid, cfg_base, cfg_first, cfg_last, cfg_reps, cfg_settle, abort
//     observes cfg_ready, dut_inputs, trig, cur_index, busy, done, err
//   slave  : the sequencer itself (directions mirrored)
interface flip_sweep_sequencer_if #(
  parameter int NUM_INS  = 32,
  parameter int IDX_W    = 16,
  parameter int REPS_W   = 8,
  parameter int SETTLE_W = 8
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [NUM_INS-1:0]  cfg_base;
  logic [IDX_W-1:0]    cfg_first;
  logic [IDX_W-1:0]    cfg_last;
  logic [REPS_W-1:0]   cfg_reps;
  logic [SETTLE_W-1:0] cfg_settle;
  logic                abort;
  logic [NUM_INS-1:0]  dut_inputs;
  logic                trig;
  logic [IDX_W-1:0]    cur_index;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cfg_valid, cfg_base, cfg_first, cfg_last, cfg_reps, cfg_settle, abort,
    input  cfg_ready, dut_inputs, trig, cur_index, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_base, cfg_first, cfg_last, cfg_reps, cfg_settle, abort,
    output cfg_ready, dut_inputs, trig, cur_index, busy, done, err
  );
endinterface

// File: rtl/flip_sweep_sequencer.sv
// flip_sweep_sequencer
//   Takes one sweep configuration and walks the DUT input vector through
//   base / base-with-one-bit-flipped pairs for every bit index in
//   [cfg_first, cfg_last], repeating each pair cfg_reps times (0 counts as 1)
//   and holding every phase for cfg_settle+1 cycles. trig marks the first
//   cycle of each flipped phase for a scope; done pulses on normal completion;
//   err is a sticky flag for a rejected configuration (cleared by the next
//   accepted one).
//   Ports:
//     flip_clk : clock, rising edge
//     reset    : asynchronous, active-low
//     sweep    : flip_sweep_sequencer_if.slave (handshake, abort, outputs)
//   cfg_ready and busy are decoded from the state register; every other
//   output is registered, so there is no combinational path from cfg_* to
//   any output.
module flip_sweep_sequencer #(
  parameter int NUM_INS  = 32,
  parameter int IDX_W    = 16,
  parameter int REPS_W   = 8,
  parameter int SETTLE_W = 8
) (
  input  logic                     flip_clk,
  input  logic                     reset,
  flip_sweep_sequencer_if.slave    sweep
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BASE = 2'd1,
    FLIP = 2'd2
  } state_t;

  state_t              state;

  // Latched sweep configuration (data only, loaded on an accepted handshake).
  logic [NUM_INS-1:0]  base_q;
  logic [IDX_W-1:0]    last_q;
  logic [REPS_W-1:0]   reps_m1_q;
  logic [SETTLE_W-1:0] settle_q;

  // Control counters.
  logic [SETTLE_W-1:0] hold_cnt;
  logic [REPS_W-1:0]   rep_cnt;

  logic                cfg_take;
  logic                cfg_good;
  logic                cfg_accept;

  // One-hot mask for the bit being flipped; idx is always < NUM_INS here.
  function automatic logic [NUM_INS-1:0] flip_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_INS-1:0] one;
    one = {{(NUM_INS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // A range is usable only when it is ordered and lies inside the DUT vector.
  // The 32-bit widening keeps cfg_last = 2^IDX_W-1 comparable against NUM_INS.
  function automatic logic range_ok(input logic [IDX_W-1:0] first,
                                    input logic [IDX_W-1:0] last);
    return (first <= last) && (32'(last) < 32'(NUM_INS));
  endfunction

  // Repeat count is stored as "remaining after the first pair", 0 meaning 1.
  function automatic logic [REPS_W-1:0] reps_minus_one(input logic [REPS_W-1:0] reps);
    return (reps == '0) ? '0 : reps - 1'b1;
  endfunction

  assign sweep.cfg_ready = (state == IDLE);
  assign sweep.busy      = (state != IDLE);

  assign cfg_take   = (state == IDLE) && sweep.cfg_valid;
  assign cfg_good   = range_ok(sweep.cfg_first, sweep.cfg_last);
  assign cfg_accept = cfg_take && cfg_good;

  // Configuration capture
  always_ff @(posedge flip_clk) begin
    if (cfg_accept) begin
      base_q    <= sweep.cfg_base;
      last_q    <= sweep.cfg_last;
      reps_m1_q <= reps_minus_one(sweep.cfg_reps);
      settle_q  <= sweep.cfg_settle;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge flip_clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      rep_cnt          <= '0;
      sweep.dut_inputs <= '0;
      sweep.trig       <= 1'b0;
      sweep.cur_index  <= '0;
      sweep.done       <= 1'b0;
      sweep.err        <= 1'b0;
    end else begin
      sweep.trig <= 1'b0;
      sweep.done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_take) begin
            if (cfg_good) begin
              sweep.err        <= 1'b0;
              sweep.cur_index  <= sweep.cfg_first;
              sweep.dut_inputs <= sweep.cfg_base;
              hold_cnt         <= sweep.cfg_settle;
              rep_cnt          <= reps_minus_one(sweep.cfg_reps);
              state            <= BASE;
            end else begin
              // Rejected: flag it, keep driving whatever the DUT already sees.
              sweep.err <= 1'b1;
            end
          end
        end

        BASE: begin
          if (sweep.abort) begin
            sweep.dut_inputs <= base_q;
            state            <= IDLE;
          end else if (hold_cnt == '0) begin
            sweep.dut_inputs <= base_q ^ flip_mask(sweep.cur_index);
            sweep.trig       <= 1'b1;
            hold_cnt         <= settle_q;
            state            <= FLIP;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        FLIP: begin
          if (sweep.abort) begin
            sweep.dut_inputs <= base_q;
            state            <= IDLE;
          end else if (hold_cnt == '0) begin
            // Every exit from FLIP returns the DUT to the base pattern.
            sweep.dut_inputs <= base_q;
            hold_cnt         <= settle_q;
            if (rep_cnt != '0) begin
              rep_cnt <= rep_cnt - 1'b1;
              state   <= BASE;
            end else if (sweep.cur_index < last_q) begin
              // cur_index < last_q < NUM_INS, so the increment cannot wrap.
              sweep.cur_index <= sweep.cur_index + 1'b1;
              rep_cnt         <= reps_m1_q;
              state           <= BASE;
            end else begin
              sweep.done <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
